arbitro_barreras: RTL and testbench
===================================

Name: arbitro_barreras

Overview:
- Controller for the parking-lot occupancy datapath.
- Two entrance lanes, each with a barrier, and one exit lane share a single occupancy counter.
- Arbitrates entrance requests round-robin and opens at most one barrier at a time, only when capacity allows.
- Sequences the counter from per-lane sensor pulses, closes the barrier on passage or timeout, and reports occupancy, full and error status to the LED/display logic.

Parameters:
- CAPACIDAD, 7: maximum cars allowed; the full flag asserts at this count.
- W_CNT, 3: occupancy width; requires CAPACIDAD <= 2^W_CNT - 1.
- T_ABIERTA, 50000000: cycles a granted barrier stays open waiting for passage.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level; req[i]=1 means a car is waiting at entrance i.
- paso  input  2  1-cycle pulse; car passed entrance i (entry pulse from that lane's sensor FSM).
- salida  input  1  1-cycle pulse; car left via the exit lane (exit pulse from the exit sensor FSM).
- barrera  output  2  barrera[i]=1 means barrier i is open; one-hot or zero.
- ocupacion  output  W_CNT  current car count.
- lleno  output  1  ocupacion == CAPACIDAD.
- ocupado  output  1  a barrier is open (FSM not idle).
- err_intruso  output  1  1-cycle pulse: paso[i] arrived while barrier i was closed.
- err_vacio  output  1  1-cycle pulse: salida arrived with ocupacion == 0.

Behaviour:
- Reset: barrera=0, ocupacion=0, lleno=0, ocupado=0, both error outputs 0, state=IDLE, round-robin pointer ultimo=1 (lane 0 is served first), timer=0. Reset asserted mid-operation closes any open barrier on the next edge.
- All outputs are registered.
- State IDLE:
  - Grant only if some req[i]=1 and ocupacion < CAPACIDAD.
  - If one lane requests, grant it. If both request, grant lane !ultimo.
  - On grant at edge N: barrera[g]=1 from cycle N+1, timer loads T_ABIERTA, state=ABIERTA, ultimo=g.
- State ABIERTA, granted lane g:
  - paso[g]=1: next cycle ocupacion+1, barrera=0, state=IDLE.
  - Timer reaching 0 without paso[g]: barrera=0, state=IDLE, count unchanged; the lane loses its turn.
  - Timer decrements once per cycle while in ABIERTA.
  - A new grant is possible on the cycle after returning to IDLE.
- paso on a non-granted or closed lane (any state): ignored for counting; err_intruso pulses for one cycle.
- salida: accepted in any state.
  - ocupacion > 0: decrement next cycle.
  - ocupacion == 0: no change; err_vacio pulses.
- Same-cycle paso[g] and salida: net zero, ocupacion unchanged, barrier still closes.
- Arithmetic: ocupacion never wraps; it is held within 0..CAPACIDAD. Overflow cannot occur because barriers only open while below capacity.
- lleno is recomputed from the next value of ocupacion. While lleno=1, requests stay pending with no grant. Grant resumes the cycle after a salida makes room.
- req dropping while the barrier is open does not close it; only paso or timeout close it.

Decomposition:
- Shared package: state encoding (IDLE, ABIERTA), N_CARRILES=2, lane index type, and the derived timer width clog2(T_ABIERTA+1).
- One sub-module, temporizador: loadable down-counter with a load and an expired flag, parameterized by width. Reusable for other lane timeouts.

Test Plan (bench overrides T_ABIERTA=8, CAPACIDAD=3):
- Reset, then req=01 held → barrera=01 one cycle after sampling; paso=01 pulse → next cycle ocupacion=1, barrera=00.
- req=11 held continuously → grants alternate lane 0, lane 1, lane 0 across successive paso pulses; ocupacion=3, lleno=1, no further grant.
- At ocupacion=3 with req=10 held: salida pulse → ocupacion=2, lleno=0; barrera=10 on the following grant.
- req=01, no paso for 8 cycles → barrera returns to 00, ocupacion unchanged; with req=11 the next grant goes to lane 1.
- paso=10 while barrera=01 → err_intruso one pulse, ocupacion unchanged. salida with ocupacion=0 → err_vacio pulse, ocupacion stays 0.
- Simultaneous paso[g] and salida at ocupacion=2 → ocupacion=2, barrier closes. reset asserted while barrera=01 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/arbitro_barreras_pkg.sv
// Shared types for the parking-lot barrier arbiter: FSM states,
// lane index type and the timer-width helper.
package arbitro_barreras_pkg;

    localparam int N_CARRILES = 2;

    typedef logic [$clog2(N_CARRILES)-1:0] carril_t;

    typedef enum logic {
        IDLE,
        ABIERTA
    } estado_t;

    // Bits needed to hold a timeout value of t cycles.
    function automatic int ancho_temp(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/arbitro_barreras_temporizador.sv
// Loadable down-counter used as a barrier timeout.
// Ports: clk, reset (sync, high), carga/valor load, en decrement, expira flag.
module arbitro_barreras_temporizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic [W-1:0] valor,
    input  logic         en,
    output logic         expira
);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (en && cuenta != '0) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    // High on the cycle whose decrement takes the count to zero, so a
    // loaded value of T keeps the owner busy for exactly T cycles.
    assign expira = (cuenta <= W'(1));

endmodule

// File: rtl/arbitro_barreras.sv
// Round-robin arbiter for two entrance barriers sharing one occupancy count.
// Ports: req/paso per entrance, salida exit pulse; barrera, ocupacion,
// lleno, ocupado and one-cycle error pulses, all registered.
module arbitro_barreras
    import arbitro_barreras_pkg::*;
#(
    parameter int CAPACIDAD = 7,
    parameter int W_CNT     = 3,
    parameter int T_ABIERTA = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       paso,
    input  logic             salida,
    output logic [1:0]       barrera,
    output logic [W_CNT-1:0] ocupacion,
    output logic             lleno,
    output logic             ocupado,
    output logic             err_intruso,
    output logic             err_vacio
);

    localparam int W_TMR = ancho_temp(T_ABIERTA);
    localparam logic [W_CNT-1:0] CAP = W_CNT'(CAPACIDAD);
    localparam logic [W_TMR-1:0] T_CARGA = W_TMR'(T_ABIERTA);

    estado_t          estado, est_sig;
    carril_t          ultimo, ultimo_sig, g;
    logic [1:0]       barrera_sig;
    logic [W_CNT-1:0] ocup_sig;
    logic             carga, expira, inc, dec, intruso, vacio;

    arbitro_barreras_temporizador #(.W(W_TMR)) u_temp (
        .clk    (clk),
        .reset  (reset),
        .carga  (carga),
        .valor  (T_CARGA),
        .en     (estado == ABIERTA),
        .expira (expira)
    );

    always_comb begin
        est_sig     = estado;
        barrera_sig = barrera;
        ultimo_sig  = ultimo;
        carga       = 1'b0;
        g           = ultimo;
        // barrera mirrors the granted lane, so it tells valid passages
        // apart from intruders in either state.
        inc         = |(paso & barrera);
        intruso     = |(paso & ~barrera);
        unique case (estado)
            IDLE: begin
                if (|req && ocupacion < CAP) begin
                    if (&req) g = ~ultimo;
                    else      g = carril_t'(req[1]);
                    carga          = 1'b1;
                    est_sig        = ABIERTA;
                    ultimo_sig     = g;
                    barrera_sig    = '0;
                    barrera_sig[g] = 1'b1;
                end
            end
            ABIERTA: begin
                if (inc || expira) begin
                    est_sig     = IDLE;
                    barrera_sig = '0;
                end
            end
            default: ;
        endcase
        // An exit at zero occupancy still cancels a same-cycle entry.
        dec      = salida && (ocupacion != '0 || inc);
        vacio    = salida && ocupacion == '0 && !inc;
        ocup_sig = ocupacion;
        if (inc && !dec)      ocup_sig = ocupacion + 1'b1;
        else if (dec && !inc) ocup_sig = ocupacion - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= IDLE;
            ultimo      <= carril_t'(1);
            barrera     <= '0;
            ocupacion   <= '0;
            lleno       <= 1'b0;
            ocupado     <= 1'b0;
            err_intruso <= 1'b0;
            err_vacio   <= 1'b0;
        end else begin
            estado      <= est_sig;
            ultimo      <= ultimo_sig;
            barrera     <= barrera_sig;
            ocupacion   <= ocup_sig;
            lleno       <= (ocup_sig == CAP);
            ocupado     <= (est_sig == ABIERTA);
            err_intruso <= intruso;
            err_vacio   <= vacio;
        end
    end

endmodule

// File: tb/tb_arbitro_barreras.sv
// Directed self-checking bench for arbitro_barreras
// (T_ABIERTA=8, CAPACIDAD=3).
module tb_arbitro_barreras;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [1:0] paso;
    logic       salida;
    logic [1:0] barrera;
    logic [2:0] ocupacion;
    logic       lleno;
    logic       ocupado;
    logic       err_intruso;
    logic       err_vacio;

    int checks = 0;
    int errors = 0;

    arbitro_barreras #(
        .CAPACIDAD (3),
        .W_CNT     (3),
        .T_ABIERTA (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .paso        (paso),
        .salida      (salida),
        .barrera     (barrera),
        .ocupacion   (ocupacion),
        .lleno       (lleno),
        .ocupado     (ocupado),
        .err_intruso (err_intruso),
        .err_vacio   (err_vacio)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] b,
                           input logic [2:0] o, input logic l,
                           input logic oc);
        chk({tag, ".barrera"}, {6'd0, barrera}, {6'd0, b});
        chk({tag, ".ocupacion"}, {5'd0, ocupacion}, {5'd0, o});
        chk({tag, ".lleno"}, {7'd0, lleno}, {7'd0, l});
        chk({tag, ".ocupado"}, {7'd0, ocupado}, {7'd0, oc});
    endtask

    initial begin
        reset = 1'b1; req = 2'b00; paso = 2'b00; salida = 1'b0;
        step(2);
        reset = 1'b0;
        chk_all("reset", 2'b00, 3'd0, 1'b0, 1'b0);
        chk("reset.intruso", {7'd0, err_intruso}, 8'd0);
        chk("reset.vacio", {7'd0, err_vacio}, 8'd0);

        // Single lane grant and passage
        req = 2'b01;
        step();
        chk_all("t1.grant", 2'b01, 3'd0, 1'b0, 1'b1);
        req = 2'b00; paso = 2'b01;
        step();
        paso = 2'b00;
        chk_all("t1.paso", 2'b00, 3'd1, 1'b0, 1'b0);

        // Fresh start: both lanes requesting, round robin to full
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("t2.reset", 2'b00, 3'd0, 1'b0, 1'b0);
        req = 2'b11;
        step();
        chk("t2.g0", {6'd0, barrera}, 8'h01);
        paso = 2'b01;
        step();
        paso = 2'b00;
        chk_all("t2.p0", 2'b00, 3'd1, 1'b0, 1'b0);
        step();
        chk("t2.g1", {6'd0, barrera}, 8'h02);
        paso = 2'b10;
        step();
        paso = 2'b00;
        chk_all("t2.p1", 2'b00, 3'd2, 1'b0, 1'b0);
        step();
        chk("t2.g2", {6'd0, barrera}, 8'h01);
        paso = 2'b01;
        step();
        paso = 2'b00;
        chk_all("t2.p2", 2'b00, 3'd3, 1'b1, 1'b0);
        step(3);
        chk_all("t2.full", 2'b00, 3'd3, 1'b1, 1'b0);

        // Exit makes room, pending lane 1 gets the grant after
        req = 2'b10; salida = 1'b1;
        step();
        salida = 1'b0;
        chk_all("t3.salida", 2'b00, 3'd2, 1'b0, 1'b0);
        step();
        chk_all("t3.grant", 2'b10, 3'd2, 1'b0, 1'b1);
        req = 2'b00; paso = 2'b10;
        step();
        paso = 2'b00;
        chk_all("t3.paso", 2'b00, 3'd3, 1'b1, 1'b0);
        salida = 1'b1;
        step();
        salida = 1'b0;
        chk_all("t3.out", 2'b00, 3'd2, 1'b0, 1'b0);

        // Timeout on lane 0 with an intruder on lane 1 meanwhile
        req = 2'b01;
        step();
        chk_all("t4.grant", 2'b01, 3'd2, 1'b0, 1'b1);
        req = 2'b00; paso = 2'b10;
        step();
        paso = 2'b00;
        chk("t4.intruso", {7'd0, err_intruso}, 8'd1);
        chk_all("t4.intr", 2'b01, 3'd2, 1'b0, 1'b1);
        step();
        chk("t4.intruso_end", {7'd0, err_intruso}, 8'd0);
        step(5);
        chk("t4.still_open", {6'd0, barrera}, 8'h01);
        step(3);
        chk_all("t4.timeout", 2'b00, 3'd2, 1'b0, 1'b0);
        req = 2'b11;
        step();
        chk("t4.turn", {6'd0, barrera}, 8'h02);

        // Same-cycle passage and exit: net zero, barrier closes
        req = 2'b00; paso = 2'b10; salida = 1'b1;
        step();
        paso = 2'b00; salida = 1'b0;
        chk_all("t5.net0", 2'b00, 3'd2, 1'b0, 1'b0);
        chk("t5.vacio", {7'd0, err_vacio}, 8'd0);

        // Reset while a barrier is open
        req = 2'b01;
        step();
        chk("t6.open", {6'd0, barrera}, 8'h01);
        reset = 1'b1;
        step();
        reset = 1'b0; req = 2'b00;
        chk_all("t6.reset", 2'b00, 3'd0, 1'b0, 1'b0);

        // Exit with empty lot
        salida = 1'b1;
        step();
        salida = 1'b0;
        chk("t7.vacio", {7'd0, err_vacio}, 8'd1);
        chk("t7.ocup", {5'd0, ocupacion}, 8'd0);
        step();
        chk("t7.vacio_end", {7'd0, err_vacio}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
